moore_1010_seq_det_non_over: RTL and testbench
==============================================

MOORE_1010_SEQ_DET_NON_OVER -- requirements
Module: moore_1010_seq_det_non_over

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have the following ports, in this order:
- Clk  input  1  system clock, rising-edge active
- Rst  input  1  asynchronous reset, active-high
- In  input  1  serial data bit, sampled on each rising Clk edge
- OP  output  1  detection flag, high while the FSM is in the DETECT state
- CS  output  3  current-state register value, for observation
- NS  output  3  combinational next-state value, for observation
REQ-003 The block SHALL have no parameters.

Function
REQ-004 The block SHALL be a Moore FSM that detects the serial pattern 1,0,1,0, with In consumed in time order and the first bit received first.
REQ-005 Detection SHALL be non-overlapping: after a detection, no bits of the matched pattern are reused for the next match.
REQ-006 State encoding SHALL be fixed and visible on CS/NS:
- S0 = 000, idle
- S1 = 001, seen "1"
- S2 = 010, seen "10"
- S3 = 011, seen "101"
- S4 = 100, DETECT, seen "1010"
REQ-007 Transitions SHALL be (In=0 / In=1):
- S0: S0 / S1
- S1: S2 / S1
- S2: S0 / S3
- S3: S4 / S1
- S4: S0 / S1
REQ-008 Unused encodings 101, 110 and 111 SHALL have next state S0, with OP=0.
REQ-009 NS SHALL be a purely combinational function of CS and In.
REQ-010 CS SHALL load NS on every rising Clk edge while Rst is low.
REQ-011 OP SHALL be a combinational decode of CS only: 1 iff CS==S4, otherwise 0.
REQ-012 OP SHALL NOT depend on In and SHALL NOT glitch on In changes between clock edges.
REQ-013 Latency: OP SHALL go high in the clock cycle immediately following the rising edge that samples the final "0" of the pattern.
REQ-014 OP SHALL stay high for exactly one clock period per detection.
REQ-015 Back-to-back S4 SHALL be impossible: OP is never high for two consecutive cycles.
REQ-016 In changing between clock edges SHALL have no effect on CS; only the value present at the rising edge matters.

Reset
REQ-017 While Rst=1, CS SHALL be forced to S0 (000) immediately, independent of Clk.
REQ-018 While Rst=1, OP SHALL be 0, and NS SHALL still reflect the combinational function of S0 and In.
REQ-019 Reset asserted mid-sequence, including while in S4, SHALL discard all partial-match history.
REQ-020 After Rst deasserts, the first rising edge SHALL evaluate the S0 transition with the sampled In.

Verification
REQ-021 Reset check: Rst=1 asynchronously at any time -> CS=000 and OP=0 without waiting for a clock edge; In=1 during reset -> NS=001.
REQ-022 Basic detect: bits 1,0,1,0 from S0 -> CS sequence 001,010,011,100; OP=1 for one cycle, then In=0 -> CS=000, OP=0.
REQ-023 Non-overlap: bits 1,0,1,0,1,0 -> exactly one OP pulse, final CS=010. Bits 1,0,1,0,1,0,1,0 -> exactly two OP pulses, four cycles apart.
REQ-024 Prefix recovery: bits 1,1,0,1,0 -> one OP pulse after the fifth bit. Bits 1,0,1,1,0,1,0 -> one OP pulse after the seventh bit, with S3 on In=1 returning to S1. Bits 1,0,0 -> CS=000.
REQ-025 Reset mid-pattern: bits 1,0,1, then Rst pulse, then 0 -> CS=000 and no OP pulse.
REQ-026 Mid-cycle input changes: In toggled between edges (e.g. change 3 ns after an edge) -> only edge-sampled values affect CS; OP is unchanged between edges.

Source files
------------

// File: rtl/moore_1010_seq_det_non_over.sv
// rtl/moore_1010_seq_det_non_over.sv - Moore FSM detecting serial pattern 1010, non-overlapping
module moore_1010_seq_det_non_over (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       In,
    output logic       OP,
    output logic [2:0] CS,
    output logic [2:0] NS
);

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_t;

    state_t cs;
    state_t ns;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cs <= S0;
        end else begin
            cs <= ns;
        end
    end

    // S4 leaves through the same arcs as S0, so a detection never seeds the next match
    always_comb begin
        ns = S0;
        case (cs)
            S0:      ns = In ? S1 : S0;
            S1:      ns = In ? S1 : S2;
            S2:      ns = In ? S3 : S0;
            S3:      ns = In ? S1 : S4;
            S4:      ns = In ? S1 : S0;
            default: ns = S0;
        endcase
    end

    assign OP = (cs == S4);
    assign CS = cs;
    assign NS = ns;

endmodule

// File: tb/tb_moore_1010_seq_det_non_over.sv
// tb/tb_moore_1010_seq_det_non_over.sv - scoreboard bench for the 1010 Moore detector
module tb_moore_1010_seq_det_non_over;

    logic       Clk;
    logic       Rst;
    logic       In;
    logic       OP;
    logic [2:0] CS;
    logic [2:0] NS;

    int checks;
    int errors;
    logic [2:0] model_cs;
    logic [2:0] exp_q[$];
    int pulse_steps[$];

    moore_1010_seq_det_non_over dut (
        .Clk(Clk),
        .Rst(Rst),
        .In (In),
        .OP (OP),
        .CS (CS),
        .NS (NS)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [2:0] mnext(input logic [2:0] s, input logic b);
        logic [2:0] r;
        r = 3'd0;
        if (s == 3'd0) r = b ? 3'd1 : 3'd0;
        else if (s == 3'd1) r = b ? 3'd1 : 3'd2;
        else if (s == 3'd2) r = b ? 3'd3 : 3'd0;
        else if (s == 3'd3) r = b ? 3'd1 : 3'd4;
        else if (s == 3'd4) r = b ? 3'd1 : 3'd0;
        return r;
    endfunction

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One bit: drive at negedge, sample 1 ns after posedge, then wiggle In mid-cycle
    task automatic step(input logic b, input int idx);
        logic [2:0] e;
        @(negedge Clk);
        In = b;
        #1;
        chk3("ns_comb", NS, mnext(model_cs, b));
        exp_q.push_back(mnext(model_cs, b));
        model_cs = mnext(model_cs, b);
        @(posedge Clk);
        #1;
        if (exp_q.size() == 0) begin
            chki("scoreboard_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk3("cs_after_edge", CS, e);
            chk1("op_after_edge", OP, e == 3'd4);
            if (OP === 1'b1) pulse_steps.push_back(idx);
            #2;
            In = ~b;
            #1;
            chk3("cs_midcycle", CS, e);
            chk1("op_midcycle", OP, e == 3'd4);
        end
    endtask

    task automatic run(input logic [15:0] bits, input int n);
        pulse_steps.delete();
        for (int i = 0; i < n; i++) step(bits[n-1-i], i);
    endtask

    task automatic async_reset();
        #2;
        Rst = 1'b1;
        #1;
        chk3("rst_cs_async", CS, 3'b000);
        chk1("rst_op_async", OP, 1'b0);
        In = 1'b1;
        #1;
        chk3("rst_ns_in1", NS, 3'b001);
        In = 1'b0;
        #1;
        chk3("rst_ns_in0", NS, 3'b000);
        @(posedge Clk);
        #1;
        chk3("rst_cs_held", CS, 3'b000);
        @(negedge Clk);
        Rst = 1'b0;
        model_cs = 3'd0;
        exp_q.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_cs = 3'd0;
        Rst = 1'b1;
        In = 1'b0;
        #12;
        chk3("reset_cs", CS, 3'b000);
        chk1("reset_op", OP, 1'b0);
        @(negedge Clk);
        Rst = 1'b0;

        run(16'b10100, 5);
        chki("basic_pulses", pulse_steps.size(), 1);
        chk3("basic_final", CS, 3'b000);

        async_reset();
        run(16'b101010, 6);
        chki("nonover6_pulses", pulse_steps.size(), 1);
        chk3("nonover6_final", CS, 3'b010);

        async_reset();
        run(16'b10101010, 8);
        chki("nonover8_pulses", pulse_steps.size(), 2);
        if (pulse_steps.size() == 2)
            chki("nonover8_gap", pulse_steps[1] - pulse_steps[0], 4);

        async_reset();
        run(16'b11010, 5);
        chki("prefix11010_pulses", pulse_steps.size(), 1);
        if (pulse_steps.size() == 1) chki("prefix11010_at", pulse_steps[0], 4);

        async_reset();
        run(16'b1011010, 7);
        chki("prefix1011010_pulses", pulse_steps.size(), 1);
        if (pulse_steps.size() == 1) chki("prefix1011010_at", pulse_steps[0], 6);

        async_reset();
        run(16'b100, 3);
        chk3("prefix100_final", CS, 3'b000);

        async_reset();
        run(16'b101, 3);
        chk3("midpat_cs", CS, 3'b011);
        async_reset();
        run(16'b0, 1);
        chki("midpat_pulses", pulse_steps.size(), 0);
        chk3("midpat_final", CS, 3'b000);

        async_reset();
        run(16'b1010, 4);
        chk1("s4_reached", OP, 1'b1);
        async_reset();
        chk1("s4_reset_op", OP, 1'b0);
        run(16'b0, 1);
        chk3("s4_reset_final", CS, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: observed no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
